// File: rtl/nes_poll_scheduler_pkg.sv
// nes_pkg: shared definitions for the NES controller poll scheduler.
//   - nes_state_e : bus sequencer states
//   - NES_BTN_*   : bit position of each button in a button word
//   - NES_LATCH_PHASES / NES_BITS : latch length in phases, bits per frame
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CK_LO,
    ST_CK_HI,
    ST_DONE
  } nes_state_e;

  localparam int NES_BTN_A      = 0;
  localparam int NES_BTN_B      = 1;
  localparam int NES_BTN_SELECT = 2;
  localparam int NES_BTN_START  = 3;
  localparam int NES_BTN_UP     = 4;
  localparam int NES_BTN_DOWN   = 5;
  localparam int NES_BTN_LEFT   = 6;
  localparam int NES_BTN_RIGHT  = 7;

  localparam int NES_LATCH_PHASES = 2;
  localparam int NES_BITS         = 8;

endpackage

// File: rtl/nes_poll_scheduler_if.sv
// nes_poll_scheduler_if: pin-side bus (ps, ck, data0/1) plus host-side
// request/result signals of the poll scheduler.
//   master : environment / host side (drives data0, data1, poll_req)
//   slave  : scheduler side (drives ps, ck, poll_busy, valid, button words)
// Macro NES_POLL_EDGES_EN adds pressed0/1 and released0/1.
interface nes_poll_scheduler_if;
  import nes_pkg::*;

  logic                ps, ck, data0, data1;
  logic                poll_req, poll_busy, valid;
  logic [NES_BITS-1:0] buttons0, buttons1;
`ifdef NES_POLL_EDGES_EN
  logic [NES_BITS-1:0] pressed0, pressed1, released0, released1;

  modport master (input ps, ck, poll_busy, valid, buttons0, buttons1,
                  pressed0, pressed1, released0, released1,
                  output data0, data1, poll_req);
  modport slave  (output ps, ck, poll_busy, valid, buttons0, buttons1,
                  pressed0, pressed1, released0, released1,
                  input data0, data1, poll_req);
`else
  modport master (input ps, ck, poll_busy, valid, buttons0, buttons1,
                  output data0, data1, poll_req);
  modport slave  (output ps, ck, poll_busy, valid, buttons0, buttons1,
                  input data0, data1, poll_req);
`endif

endinterface

// File: rtl/nes_poll_scheduler_phase_timer.sv
// nes_phase_timer: divides the system clock into bus phases of CLK_DIV clocks.
//   clock, reset : system clock, async active-low reset
//   clr_i        : synchronous restart of the divider (phase begins next clock)
//   phase_end_o  : high on the last clock of every phase
module nes_phase_timer #(
  parameter int CLK_DIV = 128
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  output logic phase_end_o
);
  localparam int W = $clog2(CLK_DIV);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                  cnt_q <= '0;
    else if (clr_i || cnt_q == W'(CLK_DIV - 1))  cnt_q <= '0;
    else                                         cnt_q <= cnt_q + 1'b1;
  end

  assign phase_end_o = (cnt_q == W'(CLK_DIV - 1));

endmodule

// File: rtl/nes_poll_scheduler.sv
// nes_poll_scheduler: drives the shared NES latch/clock lines, samples both
// controller ports in lockstep and publishes one button word per port with a
// one-cycle valid strobe. Polls start periodically (AUTO_POLL) or on poll_req;
// a request during a poll is held as one pending poll.
//   clock, reset : 12.5 MHz system clock, async active-low reset
//   bus (slave)  : ps/ck out, data0/data1 in (active-low), poll_req in,
//                  poll_busy/valid/buttons0/buttons1 out
// Macro NES_POLL_EDGES_EN: adds registered pressed/released edge words.
module nes_poll_scheduler
  import nes_pkg::*;
#(
  parameter int CLK_DIV     = 128,
  parameter int POLL_PERIOD = 512,
  parameter bit AUTO_POLL   = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  nes_poll_scheduler_if.slave  bus
);
  localparam int IW = $clog2(POLL_PERIOD);

  nes_state_e          state_q;
  logic [2:0]          bit_q;
  logic [IW-1:0]       ivl_q;
  logic                pend_q, ps_q, ck_q, busy_q, valid_q;
  logic [1:0]          s0_q, s1_q;
  logic [NES_BITS-1:0] sh0_q, sh1_q, btn0_q, btn1_q, new0, new1;
  logic                phase_end, expired, start;
`ifdef NES_POLL_EDGES_EN
  logic [NES_BITS-1:0] pr0_q, pr1_q, rl0_q, rl1_q;
`endif

  nes_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clock       (clock),
    .reset       (reset),
    .clr_i       (start),
    .phase_end_o (phase_end)
  );

  // Expiry fires on the last clock of phase POLL_PERIOD-1 so the start edge
  // lands exactly POLL_PERIOD phases after the previous start.
  assign expired = AUTO_POLL && phase_end && (ivl_q == IW'(POLL_PERIOD - 1));
  // DONE may launch a pending poll directly, giving a 1-clock gap after valid.
  assign start   = (state_q == ST_IDLE || state_q == ST_DONE) &&
                   (bus.poll_req || pend_q || expired);

  // Shift word with the bit currently being sampled merged in (1 = pressed).
  always_comb begin
    new0        = sh0_q;
    new1        = sh1_q;
    new0[bit_q] = ~s0_q[1];
    new1[bit_q] = ~s1_q[1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s0_q <= 2'b11;
      s1_q <= 2'b11;
    end else begin
      s0_q <= {s0_q[0], bus.data0};
      s1_q <= {s1_q[0], bus.data1};
    end
  end

  // Interval counter saturates so it never wraps when auto polling is off.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                             ivl_q <= '0;
    else if (start)                                         ivl_q <= '0;
    else if (phase_end && ivl_q != IW'(POLL_PERIOD - 1))    ivl_q <= ivl_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      pend_q  <= 1'b0;
      ps_q    <= 1'b0;
      ck_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      btn0_q  <= '0;
      btn1_q  <= '0;
`ifdef NES_POLL_EDGES_EN
      pr0_q   <= '0;
      pr1_q   <= '0;
      rl0_q   <= '0;
      rl1_q   <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (start) begin
        state_q <= ST_LATCH;
        bit_q   <= '0;
        pend_q  <= 1'b0;
        ps_q    <= 1'b1;
        ck_q    <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        // Only reachable while a poll is on the bus: idle requests start.
        if (bus.poll_req) pend_q <= 1'b1;
        unique case (state_q)
          ST_IDLE: ;
          ST_LATCH: if (phase_end) begin
            // bit_q doubles as the latch phase counter.
            if (bit_q == 3'(NES_LATCH_PHASES - 1)) begin
              state_q <= ST_CK_LO;
              ps_q    <= 1'b0;
              bit_q   <= '0;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
          ST_CK_LO: if (phase_end) begin
            sh0_q <= new0;
            sh1_q <= new1;
            if (bit_q == 3'(NES_BITS - 1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
              btn0_q  <= new0;
              btn1_q  <= new1;
`ifdef NES_POLL_EDGES_EN
              pr0_q   <= new0 & ~btn0_q;
              pr1_q   <= new1 & ~btn1_q;
              rl0_q   <= ~new0 & btn0_q;
              rl1_q   <= ~new1 & btn1_q;
`endif
            end else begin
              state_q <= ST_CK_HI;
              ck_q    <= 1'b1;
            end
          end
          ST_CK_HI: if (phase_end) begin
            state_q <= ST_CK_LO;
            ck_q    <= 1'b0;
            bit_q   <= bit_q + 1'b1;
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.ps        = ps_q;
  assign bus.ck        = ck_q;
  assign bus.poll_busy = busy_q;
  assign bus.valid     = valid_q;
  assign bus.buttons0  = btn0_q;
  assign bus.buttons1  = btn1_q;
`ifdef NES_POLL_EDGES_EN
  assign bus.pressed0  = pr0_q;
  assign bus.pressed1  = pr1_q;
  assign bus.released0 = rl0_q;
  assign bus.released1 = rl1_q;
`endif

endmodule

// File: tb/tb_nes_poll_scheduler.sv
// Directed bench for nes_poll_scheduler (CLK_DIV=4, POLL_PERIOD=20).
// u_man: AUTO_POLL=0, driven by a controller model; u_auto: AUTO_POLL=1, idle lines.
module tb_nes_poll_scheduler;

  logic clk = 1'b0;
  logic rst_m = 1'b0;
  logic rst_a = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  nes_poll_scheduler_if bm();
  nes_poll_scheduler_if ba();

  nes_poll_scheduler #(.CLK_DIV(4), .POLL_PERIOD(20), .AUTO_POLL(1'b0)) u_man (
    .clock(clk), .reset(rst_m), .bus(bm.slave));
  nes_poll_scheduler #(.CLK_DIV(4), .POLL_PERIOD(20), .AUTO_POLL(1'b1)) u_auto (
    .clock(clk), .reset(rst_a), .bus(ba.slave));

  // Controller model: line levels (0 = pressed), A first, advance on ck rise.
  logic [7:0] lvl0 = 8'hFF, lvl1 = 8'hFF;
  int idx = 8;
  always @(posedge bm.ps) idx = 0;
  always @(posedge bm.ck) idx = idx + 1;
  assign bm.data0 = (idx < 8) ? lvl0[idx[2:0]] : 1'b1;
  assign bm.data1 = (idx < 8) ? lvl1[idx[2:0]] : 1'b1;
  assign ba.data0 = 1'b1;
  assign ba.data1 = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse poll_req; returns at #1 after the start edge N.
  task automatic start_poll();
    @(negedge clk) bm.poll_req = 1'b1;
    @(posedge clk); #1;
    bm.poll_req = 1'b0;
  endtask

  // Follow a poll from edge N until valid; optionally pulse poll_req at t=r1/r2.
  task automatic watch(input int r1, input int r2,
                       output int vt, output int pf, output int nr, output int hw);
    logic pck;
    vt = 0; pf = 0; nr = 0; hw = 0; pck = 1'b0;
    for (int t = 1; t <= 100; t++) begin
      @(posedge clk); #1;
      bm.poll_req = (t == r1 || t == r2);
      if (pf == 0 && !bm.ps) pf = t;
      if (bm.ck && !pck) nr++;
      if (bm.ck) hw++;
      pck = bm.ck;
      if (bm.valid) begin vt = t; break; end
    end
    bm.poll_req = 1'b0;
  endtask

`ifdef NES_POLL_EDGES_EN
  logic [7:0] ef [3] = '{8'h01, 8'h03, 8'h02};
  logic [7:0] ep [3] = '{8'h01, 8'h02, 8'h00};
  logic [7:0] er [3] = '{8'h00, 8'h00, 8'h01};
`endif

  initial begin
    int vt, pf, nr, hw, cnt_ps, cnt_ck, cnt_v, dt;
    bm.poll_req = 1'b0;
    ba.poll_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ps", bm.ps, 0);
    chk("rst_ck", bm.ck, 0);
    chk("rst_busy", bm.poll_busy, 0);
    chk("rst_valid", bm.valid, 0);
    chk("rst_b0", bm.buttons0, 0);
    chk("rst_b1", bm.buttons1, 0);
    @(negedge clk);
    rst_m = 1'b1;
    rst_a = 1'b1;

    fork
      begin : auto_branch
        int k;
        logic prev;
        k = 0;
        for (int t = 1; t <= 300; t++) begin
          @(posedge clk); #1;
          if (ba.ps) begin k = t; break; end
        end
        chk("auto_first", k, 80);
        for (int n = 0; n < 2; n++) begin
          k = 0; prev = 1'b1;
          for (int t = 1; t <= 300; t++) begin
            @(posedge clk); #1;
            if (ba.ps && !prev) begin k = t; break; end
            prev = ba.ps;
          end
          chk("auto_period", k, 80);
        end
        chk("auto_b0", ba.buttons0, 0);
      end
      begin : man_branch
        // Idle with no requests
        cnt_ps = 0; cnt_ck = 0; cnt_v = 0;
        for (int t = 0; t < 200; t++) begin
          @(posedge clk); #1;
          if (bm.ps) cnt_ps++;
          if (bm.ck) cnt_ck++;
          if (bm.valid) cnt_v++;
        end
        chk("idle_ps", cnt_ps, 0);
        chk("idle_ck", cnt_ck, 0);
        chk("idle_valid", cnt_v, 0);

        // Basic poll: A and Right held on port 0
        lvl0 = 8'h7E; lvl1 = 8'hFF;
        start_poll();
        chk("start_ps", bm.ps, 1);
        chk("start_busy", bm.poll_busy, 1);
        watch(0, 0, vt, pf, nr, hw);
        chk("p1_valid_t", vt, 68);
        chk("p1_busy_low", bm.poll_busy, 0);
        chk("p1_ps_fall", pf, 8);
        chk("p1_ck_pulses", nr, 7);
        chk("p1_ck_high", hw, 28);
        chk("p1_b0", bm.buttons0, 8'h81);
        chk("p1_b1", bm.buttons1, 8'h00);
        @(posedge clk); #1;
        chk("p1_valid_1cyc", bm.valid, 0);

        // Two requests during a poll merge into one pending poll
        repeat (5) @(posedge clk);
        lvl0 = 8'hF5; lvl1 = 8'h3C;
        start_poll();
        watch(21, 37, vt, pf, nr, hw);
        chk("pd_valid_t", vt, 68);
        dt = 0;
        for (int t = 1; t <= 10; t++) begin
          @(posedge clk); #1;
          if (bm.ps) begin dt = t; break; end
        end
        chk("pd_ps_gap", dt, 1);
        watch(0, 0, vt, pf, nr, hw);
        chk("pd2_valid_t", vt, 68);
        chk("pd2_b0", bm.buttons0, 8'h0A);
        chk("pd2_b1", bm.buttons1, 8'hC3);
        cnt_ps = 0;
        for (int t = 0; t < 100; t++) begin
          @(posedge clk); #1;
          if (bm.ps) cnt_ps++;
        end
        chk("pd_no_third", cnt_ps, 0);

        // Reset during CK_HI of bit 3
        lvl0 = 8'h7E; lvl1 = 8'hFF;
        start_poll();
        repeat (36) @(posedge clk);
        #1;
        chk("mid_ck_hi", bm.ck, 1);
        rst_m = 1'b0;
        #1;
        chk("mid_rst_ps", bm.ps, 0);
        chk("mid_rst_ck", bm.ck, 0);
        chk("mid_rst_busy", bm.poll_busy, 0);
        chk("mid_rst_valid", bm.valid, 0);
        chk("mid_rst_b0", bm.buttons0, 0);
        @(negedge clk) rst_m = 1'b1;
        repeat (2) @(posedge clk);
        start_poll();
        watch(0, 0, vt, pf, nr, hw);
        chk("post_valid_t", vt, 68);
        chk("post_b0", bm.buttons0, 8'h81);

`ifdef NES_POLL_EDGES_EN
        @(negedge clk) rst_m = 1'b0;
        @(negedge clk) rst_m = 1'b1;
        for (int f = 0; f < 3; f++) begin
          lvl0 = ~ef[f];
          start_poll();
          watch(0, 0, vt, pf, nr, hw);
          chk("edge_b0", bm.buttons0, ef[f]);
          chk("edge_pressed0", bm.pressed0, ep[f]);
          chk("edge_released0", bm.released0, er[f]);
          repeat (3) @(posedge clk);
        end
`endif
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
